// File: rtl/tcb_arbiter.sv
// tcb_arbiter: N-to-1 TCB arbiter with fixed-priority or round-robin grant, stall lock and delayed response routing
module tcb_arbiter #(
    parameter int unsigned AW         = 32,
    parameter int unsigned DW         = 32,
    parameter int unsigned BW         = DW/8,
    parameter int unsigned PN         = 2,
    parameter logic [15:0] MD         = "FX",
    parameter int unsigned PRI [0:15] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15},
    parameter int unsigned DLY        = 1,
    parameter bit          HLD        = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PN-1:0]         s_vld,
    input  logic [PN-1:0]         s_wen,
    input  logic [PN-1:0][AW-1:0] s_adr,
    input  logic [PN-1:0][BW-1:0] s_ben,
    input  logic [PN-1:0][DW-1:0] s_wdt,
    output logic [PN-1:0][DW-1:0] s_rdt,
    output logic [PN-1:0]         s_err,
    output logic [PN-1:0]         s_rdy,
    output logic                  m_vld,
    output logic                  m_wen,
    output logic [AW-1:0]         m_adr,
    output logic [BW-1:0]         m_ben,
    output logic [DW-1:0]         m_wdt,
    input  logic [DW-1:0]         m_rdt,
    input  logic                  m_err,
    input  logic                  m_rdy
);
    localparam int unsigned PW = $clog2(PN);
    localparam bit RR = (MD == "RR");

    logic [PW-1:0]          ptr_q, ptr_d;
    logic [PW-1:0]          lsel_q, lsel_d;
    logic                   lck_q, lck_d;
    logic [DLY-1:0]         rsp_vld_q, rsp_vld_d;
    logic [DLY-1:0][PW-1:0] rsp_sel_q, rsp_sel_d;
    logic [PW-1:0]          arb_sel;
    logic [31:0]            arb_pri;
    logic [PW-1:0]          gnt;
    logic                   xfer;

    // port index p+k taken modulo PN, valid for non-power-of-two PN
    function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int k);
        int t;
        t = int'(p) + k;
        return PW'(t >= int'(PN) ? t - int'(PN) : t);
    endfunction

    // free arbitration: lowest PRI (lower index on ties) or first requester from ptr
    always_comb begin
        arb_sel = '0;
        arb_pri = '1;
        for (int i = PN-1; i >= 0; i--) begin
            if (!RR && s_vld[i] && PRI[i] <= arb_pri) begin
                arb_sel = PW'(i);
                arb_pri = PRI[i];
            end
        end
        for (int k = PN-1; k >= 0; k--) begin
            if (RR && s_vld[wrap(ptr_q, k)]) arb_sel = wrap(ptr_q, k);
        end
    end

    // the lock overrides arbitration; request path and ready are muxed by the grant
    always_comb begin
        gnt = lck_q ? lsel_q : arb_sel;
        m_vld = s_vld[gnt];
        m_wen = m_vld & s_wen[gnt];
        m_adr = m_vld ? s_adr[gnt] : '0;
        m_ben = m_vld ? s_ben[gnt] : '0;
        m_wdt = m_vld ? s_wdt[gnt] : '0;
        s_rdy = '0;
        s_rdy[gnt] = m_rdy;
        xfer = m_vld & m_rdy;
    end

    // next state: rotate ptr past the served port, lock on a stall, push the grant into the response pipe
    always_comb begin
        ptr_d = (RR && xfer) ? wrap(gnt, 1) : ptr_q;
        lck_d = HLD && (lck_q ? !xfer : (m_vld && !m_rdy));
        lsel_d = (HLD && !lck_q && m_vld && !m_rdy) ? gnt : lsel_q;
        rsp_vld_d = (rsp_vld_q << 1) | DLY'(xfer);
        rsp_sel_d = '0;
        rsp_sel_d[0] = gnt;
        for (int i = 1; i < DLY; i++) rsp_sel_d[i] = rsp_sel_q[i-1];
    end

    // route the subordinate response to the port whose transfer is DLY cycles old
    always_comb begin
        s_rdt = '0;
        s_err = '0;
        if (rsp_vld_q[DLY-1]) begin
            s_rdt[rsp_sel_q[DLY-1]] = m_rdt;
            s_err[rsp_sel_q[DLY-1]] = m_err;
        end
    end

    // state registers; reset drops any responses still in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            lck_q     <= 1'b0;
            lsel_q    <= '0;
            rsp_vld_q <= '0;
            rsp_sel_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            lck_q     <= lck_d;
            lsel_q    <= lsel_d;
            rsp_vld_q <= rsp_vld_d;
            rsp_sel_q <= rsp_sel_d;
        end
    end
endmodule

// File: tb/tb_tcb_arbiter.sv
// tb_tcb_arbiter: checks an FX and an RR arbiter (PN=3, DLY=2, HLD=1) against vectors, sequences and a reference model
module tb_tcb_arbiter;
    typedef struct {
        logic [2:0] vld;
        int         port;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    logic [2:0]       vld, wen;
    logic [2:0][31:0] adr, wdt;
    logic [2:0][3:0]  ben;
    logic [31:0]      m_rdt;
    logic             m_err, m_rdy;

    logic [1:0]            o_mvld, o_mwen;
    logic [1:0][31:0]      o_madr, o_mwdt;
    logic [1:0][3:0]       o_mben;
    logic [1:0][2:0]       o_srdy, o_serr;
    logic [1:0][2:0][31:0] o_srdt;

    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    bit mon = 1'b0;
    int pri [3] = '{2, 0, 1};
    int ptr [2] = '{0, 0};
    int lck [2] = '{0, 0};
    int lsel [2] = '{0, 0};
    int sched [int];
    vec_t tbl [7];

    always #5 clk = ~clk;

    tcb_arbiter #(.AW(32), .DW(32), .PN(3), .MD("FX"),
                  .PRI('{2, 0, 1, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15}),
                  .DLY(2), .HLD(1'b1)) u_fx (
        .clk(clk), .rst(rst),
        .s_vld(vld), .s_wen(wen), .s_adr(adr), .s_ben(ben), .s_wdt(wdt),
        .s_rdt(o_srdt[0]), .s_err(o_serr[0]), .s_rdy(o_srdy[0]),
        .m_vld(o_mvld[0]), .m_wen(o_mwen[0]), .m_adr(o_madr[0]), .m_ben(o_mben[0]), .m_wdt(o_mwdt[0]),
        .m_rdt(m_rdt), .m_err(m_err), .m_rdy(m_rdy)
    );

    tcb_arbiter #(.AW(32), .DW(32), .PN(3), .MD("RR"), .DLY(2), .HLD(1'b1)) u_rr (
        .clk(clk), .rst(rst),
        .s_vld(vld), .s_wen(wen), .s_adr(adr), .s_ben(ben), .s_wdt(wdt),
        .s_rdt(o_srdt[1]), .s_err(o_serr[1]), .s_rdy(o_srdy[1]),
        .m_vld(o_mvld[1]), .m_wen(o_mwen[1]), .m_adr(o_madr[1]), .m_ben(o_mben[1]), .m_wdt(o_mwdt[1]),
        .m_rdt(m_rdt), .m_err(m_err), .m_rdy(m_rdy)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    function automatic int pick(input int d);
        int b;
        b = -1;
        if (lck[d] != 0) return lsel[d];
        for (int j = 0; j < 3; j++) begin
            int p;
            p = (d == 0) ? j : (ptr[d] + j) % 3;
            if (vld[p] && b < 0) b = p;
            else if (d == 0 && vld[p] && pri[p] < pri[b]) b = p;
        end
        return b;
    endfunction

    task automatic mchk(input int d);
        int g, rp;
        string tag;
        logic [127:0] er;
        logic [2:0][31:0] xr;
        logic [2:0] xe;
        tag = (d == 0) ? "fx" : "rr";
        g = pick(d);
        er = '0;
        if (g >= 0 && vld[g]) er = {1'b1, wen[g], ben[g], adr[g], wdt[g]};
        chk({tag, "_req"}, {o_mvld[d], o_mwen[d], o_mben[d], o_madr[d], o_mwdt[d]}, er);
        if (g >= 0) chk({tag, "_rdy"}, o_srdy[d], 3'(m_rdy) << g);
        rp = sched.exists(cyc*2 + d) ? sched[cyc*2 + d] : -1;
        xr = '0;
        xe = '0;
        if (rp >= 0) begin
            xr[rp] = m_rdt;
            xe[rp] = m_err;
        end
        chk({tag, "_rdt"}, o_srdt[d], xr);
        chk({tag, "_err"}, o_serr[d], xe);
    endtask

    task automatic mupd(input int d);
        int g;
        g = pick(d);
        if (rst) begin
            ptr[d] = 0;
            lck[d] = 0;
            lsel[d] = 0;
        end else if (g >= 0 && vld[g]) begin
            if (m_rdy) begin
                sched[(cyc + 2)*2 + d] = g;
                if (d == 1) ptr[d] = (g + 1) % 3;
                lck[d] = 0;
            end else begin
                lck[d] = 1;
                lsel[d] = g;
            end
        end
    endtask

    task automatic drive(input logic [2:0] v, input logic r);
        vld = v;
        m_rdy = r;
        for (int i = 0; i < 3; i++) begin
            adr[i] = {8'(i + 1), 24'($urandom)};
            wdt[i] = $urandom;
            ben[i] = 4'($urandom);
            wen[i] = 1'($urandom);
        end
        m_rdt = $urandom;
        m_err = 1'b0;
    endtask

    task automatic settle();
        #1;
        if (mon) begin
            mchk(0);
            mchk(1);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        mupd(0);
        mupd(1);
        if (rst) sched.delete();
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        tbl[0] = '{3'b111, 1};
        tbl[1] = '{3'b101, 2};
        tbl[2] = '{3'b001, 0};
        tbl[3] = '{3'b110, 1};
        tbl[4] = '{3'b100, 2};
        tbl[5] = '{3'b000, -1};
        tbl[6] = '{3'b011, 1};

        rst = 1'b1;
        drive(3'b000, 1'b1);
        tick();
        tick();
        rst = 1'b0;
        mon = 1'b1;

        drive(3'b000, 1'b1);
        settle();
        chk("reset_rdt", {o_srdt[1], o_srdt[0]}, '0);
        chk("reset_err_vld", {o_serr, o_mvld}, '0);
        tick();

        for (int k = 0; k < 6; k++) begin
            drive(3'b111, 1'b1);
            settle();
            chk("rr_seq", o_srdy[1], 3'b001 << (k % 3));
            chk("fx_pri", o_srdy[0], 3'b010);
            tick();
        end

        drive(3'b010, 1'b1);
        settle();
        tick();
        drive(3'b011, 1'b1);
        settle();
        chk("rr_wrap", o_srdy[1], 3'b001);
        tick();
        drive(3'b011, 1'b1);
        settle();
        chk("rr_next", o_srdy[1], 3'b010);
        tick();

        for (int k = 0; k < 7; k++) begin
            drive(tbl[k].vld, 1'b1);
            settle();
            chk("tbl_req", {o_mvld[0], o_madr[0]}, tbl[k].port < 0 ? 33'd0 : {1'b1, adr[tbl[k].port]});
            if (tbl[k].port >= 0) chk("tbl_rdy", o_srdy[0], 3'b001 << tbl[k].port);
            tick();
        end

        drive(3'b010, 1'b0);
        settle();
        chk("hold1", o_madr[0], adr[1]);
        tick();
        drive(3'b011, 1'b0);
        settle();
        chk("hold2", o_madr[0], adr[1]);
        tick();
        drive(3'b011, 1'b0);
        settle();
        chk("hold3", o_madr[0], adr[1]);
        tick();
        drive(3'b011, 1'b1);
        settle();
        chk("hold_xfer", {o_madr[0], o_srdy[0]}, {adr[1], 3'b010});
        tick();
        drive(3'b001, 1'b1);
        settle();
        chk("after_hold", o_madr[0], adr[0]);
        tick();

        drive(3'b100, 1'b0);
        settle();
        chk("lock_a", o_madr[0], adr[2]);
        tick();
        drive(3'b110, 1'b0);
        settle();
        chk("lock_b", o_madr[0], adr[2]);
        tick();
        drive(3'b110, 1'b1);
        settle();
        chk("lock_c", {o_madr[0], o_srdy[0]}, {adr[2], 3'b100});
        tick();
        drive(3'b110, 1'b1);
        settle();
        chk("lock_d", o_madr[0], adr[1]);
        tick();

        drive(3'b001, 1'b1);
        settle();
        tick();
        drive(3'b010, 1'b1);
        settle();
        tick();
        drive(3'b001, 1'b1);
        m_rdt = 32'hA0;
        settle();
        chk("rsp0", o_srdt[0], {32'h0, 32'h0, 32'hA0});
        chk("rsp0_err", o_serr[0], 3'b000);
        tick();
        drive(3'b000, 1'b1);
        m_rdt = 32'hA1;
        m_err = 1'b1;
        settle();
        chk("rsp1", o_srdt[0], {32'h0, 32'hA1, 32'h0});
        chk("rsp1_err", o_serr[0], 3'b010);
        tick();
        drive(3'b000, 1'b1);
        m_rdt = 32'hA2;
        settle();
        chk("rsp2", o_srdt[0], {32'h0, 32'h0, 32'hA2});
        chk("rsp2_err", o_serr[0], 3'b000);
        tick();

        drive(3'b001, 1'b1);
        settle();
        tick();
        rst = 1'b1;
        drive(3'b000, 1'b1);
        settle();
        tick();
        rst = 1'b0;
        drive(3'b000, 1'b1);
        m_rdt = 32'hDEAD;
        m_err = 1'b1;
        settle();
        chk("rst_rdt_fx", o_srdt[0], '0);
        chk("rst_rdt_rr", o_srdt[1], '0);
        chk("rst_err", o_serr, '0);
        tick();
        drive(3'b100, 1'b0);
        settle();
        tick();
        rst = 1'b1;
        drive(3'b000, 1'b1);
        settle();
        tick();
        rst = 1'b0;
        drive(3'b011, 1'b1);
        settle();
        chk("rst_lck", {o_mvld[0], o_madr[0], o_srdy[0]}, {1'b1, adr[1], 3'b010});
        chk("rst_ptr", o_srdy[1], 3'b001);
        tick();

        for (int k = 0; k < 400; k++) begin
            rst = ($urandom_range(0, 99) == 0);
            drive(3'($urandom), $urandom_range(0, 3) != 0);
            m_err = 1'($urandom);
            settle();
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
